// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ResultSrc/ALUOp encodings, immediate types.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNC   = 2'b10;

    // IMM_NONE covers R-type and unsupported opcodes (immediate forced to 0)
    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_NONE} imm_src_e;

    // Sign-extended immediate for the given format; all formats extend from bit 31
    function automatic logic [31:0] imm_ext(input logic [31:0] instr, input imm_src_e src);
        logic [31:0] imm;
        imm = '0;
        case (src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: IF/ID + WB + EX-feedback inputs, ID/EX-bound outputs.
interface id_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [31:0]      Instr_D;
    logic             RegWrite_W;
    logic [4:0]       Rd_W;
    logic [XLEN-1:0]  Result_W;
    logic [1:0]       ResultSrc_E;
    logic [4:0]       Rd_E;
    logic             PCSrc_E;

    logic [XLEN-1:0]  RD1_D;
    logic [XLEN-1:0]  RD2_D;
    logic [31:0]      ImmExt_D;
    logic [4:0]       Rd_D;
    logic [4:0]       Rs1_D;
    logic [4:0]       Rs2_D;
    logic [2:0]       Funct3_D;
    logic             Funct7_5_D;
    logic [1:0]       ALUOp_D;
    logic [1:0]       ResultSrc_D;
    logic             ALUSrc_D;
    logic             MemWrite_D;
    logic             RegWrite_D;
    logic             Branch_D;
    logic             IllegalInstr_D;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic [CNT_W-1:0] StallCnt;

    modport master (
        output Instr_D, RegWrite_W, Rd_W, Result_W, ResultSrc_E, Rd_E, PCSrc_E,
        input  RD1_D, RD2_D, ImmExt_D, Rd_D, Rs1_D, Rs2_D, Funct3_D, Funct7_5_D,
               ALUOp_D, ResultSrc_D, ALUSrc_D, MemWrite_D, RegWrite_D, Branch_D,
               IllegalInstr_D, StallF, StallD, FlushD, FlushE, StallCnt
    );

    modport slave (
        input  Instr_D, RegWrite_W, Rd_W, Result_W, ResultSrc_E, Rd_E, PCSrc_E,
        output RD1_D, RD2_D, ImmExt_D, Rd_D, Rs1_D, Rs2_D, Funct3_D, Funct7_5_D,
               ALUOp_D, ResultSrc_D, ALUSrc_D, MemWrite_D, RegWrite_D, Branch_D,
               IllegalInstr_D, StallF, StallD, FlushD, FlushE, StallCnt
    );
endinterface

// File: rtl/regfile_2r1w.sv
// 32-entry architectural register file: 2 comb read ports, 1 write port, optional WB bypass.
module regfile_2r1w #(
    parameter int XLEN      = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      i_ra1,
    input  logic [4:0]      i_ra2,
    input  logic            i_we,
    input  logic [4:0]      i_wa,
    input  logic [XLEN-1:0] i_wd,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2
);
    logic [XLEN-1:0] r_regs [32];
    logic [XLEN-1:0] w_st1;
    logic [XLEN-1:0] w_st2;

    // Storage: reset clears everything and beats a same-cycle write; x0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (i_we && (i_wa != 5'd0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign w_st1 = (i_ra1 == 5'd0) ? '0 : r_regs[i_ra1];
    assign w_st2 = (i_ra2 == 5'd0) ? '0 : r_regs[i_ra2];

    generate
        if (BYPASS_EN) begin : g_byp
            // WB result forwarded combinationally so ID sees it in the write cycle
            assign o_rd1 = (i_we && (i_wa == i_ra1) && (i_ra1 != 5'd0)) ? i_wd : w_st1;
            assign o_rd2 = (i_we && (i_wa == i_ra2) && (i_ra2 != 5'd0)) ? i_wd : w_st2;
        end else begin : g_nobyp
            assign o_rd1 = w_st1;
            assign o_rd2 = w_st2;
        end
    endgenerate
endmodule

// File: rtl/id_stage.sv
// RV32I Instruction Decode stage: regfile, control decode, immediate, hazard unit, stall counter.
module id_stage
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit BYPASS_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input logic       clk,
    input logic       rst,
    id_stage_if.slave io_bus
);
    logic [6:0]       w_op;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    imm_src_e         w_imm_src;
    logic [1:0]       w_aluop;
    logic [1:0]       w_ressrc;
    logic             w_alusrc;
    logic             w_memwr;
    logic             w_regwr;
    logic             w_branch;
    logic             w_illegal;
    logic             w_use_rs2;
    logic             w_lu;
    logic             w_stall;
    logic [CNT_W-1:0] r_cnt;

    assign w_op  = io_bus.Instr_D[6:0];
    assign w_rs1 = io_bus.Instr_D[19:15];
    assign w_rs2 = io_bus.Instr_D[24:20];

    regfile_2r1w #(.XLEN(XLEN), .BYPASS_EN(BYPASS_EN)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .i_ra1 (w_rs1),
        .i_ra2 (w_rs2),
        .i_we  (io_bus.RegWrite_W),
        .i_wa  (io_bus.Rd_W),
        .i_wd  (io_bus.Result_W),
        .o_rd1 (io_bus.RD1_D),
        .o_rd2 (io_bus.RD2_D)
    );

    // Main decoder: opcode -> control; anything unsupported is flagged illegal with control 0
    always_comb begin
        w_imm_src = IMM_NONE;
        w_aluop   = ALUOP_ADD;
        w_ressrc  = RES_ALU;
        w_alusrc  = 1'b0;
        w_memwr   = 1'b0;
        w_regwr   = 1'b0;
        w_branch  = 1'b0;
        w_illegal = 1'b0;
        case (w_op)
            OP_LOAD: begin
                w_regwr = 1'b1; w_alusrc = 1'b1; w_ressrc = RES_MEM; w_imm_src = IMM_I;
            end
            OP_STORE: begin
                w_memwr = 1'b1; w_alusrc = 1'b1; w_imm_src = IMM_S;
            end
            OP_R: begin
                w_regwr = 1'b1; w_aluop = ALUOP_FUNC;
            end
            OP_IMM: begin
                w_regwr = 1'b1; w_alusrc = 1'b1; w_aluop = ALUOP_FUNC; w_imm_src = IMM_I;
            end
            OP_BRANCH: begin
                w_branch = 1'b1; w_aluop = ALUOP_BRANCH; w_imm_src = IMM_B;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign io_bus.ImmExt_D       = imm_ext(io_bus.Instr_D, w_imm_src);
    assign io_bus.Rd_D           = io_bus.Instr_D[11:7];
    assign io_bus.Rs1_D          = w_rs1;
    assign io_bus.Rs2_D          = w_rs2;
    assign io_bus.Funct3_D       = io_bus.Instr_D[14:12];
    assign io_bus.Funct7_5_D     = io_bus.Instr_D[30];
    assign io_bus.ALUOp_D        = w_aluop;
    assign io_bus.ResultSrc_D    = w_ressrc;
    assign io_bus.ALUSrc_D       = w_alusrc;
    assign io_bus.MemWrite_D     = w_memwr;
    assign io_bus.RegWrite_D     = w_regwr;
    assign io_bus.Branch_D       = w_branch;
    assign io_bus.IllegalInstr_D = w_illegal;

    // rs2 only counts as a source for formats that actually read it (I-type bits 24:20 are imm)
    assign w_use_rs2 = (w_op == OP_R) || (w_op == OP_STORE) || (w_op == OP_BRANCH);
    assign w_lu = (io_bus.ResultSrc_E == RES_MEM) && (io_bus.Rd_E != 5'd0) &&
                  ((io_bus.Rd_E == w_rs1) || (w_use_rs2 && (io_bus.Rd_E == w_rs2)));

    // A taken branch makes the decoding instruction wrong-path, so flush beats stall
    assign w_stall       = !rst && w_lu && !io_bus.PCSrc_E;
    assign io_bus.StallF = w_stall;
    assign io_bus.StallD = w_stall;
    assign io_bus.FlushD = !rst && io_bus.PCSrc_E;
    assign io_bus.FlushE = !rst && (w_lu || io_bus.PCSrc_E);

    // Saturating count of load-use stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign io_bus.StallCnt = r_cnt;
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode/hazard vector table plus regfile, counter and reset sequences.
module tb_id_stage;
    localparam int CNT_W1 = 3;  // narrow counter on the second instance so saturation is reachable

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_stage_if #(.XLEN(32), .CNT_W(16))     b0 ();
    id_stage_if #(.XLEN(32), .CNT_W(CNT_W1)) b1 ();

    id_stage #(.XLEN(32), .BYPASS_EN(1'b1), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .io_bus(b0));
    id_stage #(.XLEN(32), .BYPASS_EN(1'b0), .CNT_W(CNT_W1)) dut1 (.clk(clk), .rst(rst), .io_bus(b1));

    assign b1.Instr_D     = b0.Instr_D;
    assign b1.RegWrite_W  = b0.RegWrite_W;
    assign b1.Rd_W        = b0.Rd_W;
    assign b1.Result_W    = b0.Result_W;
    assign b1.ResultSrc_E = b0.ResultSrc_E;
    assign b1.Rd_E        = b0.Rd_E;
    assign b1.PCSrc_E     = b0.PCSrc_E;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_cnt = 0;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [1:0]  rs_e;
        logic [4:0]  rd_e;
        logic        pc;
        logic        chk_imm;
        logic [31:0] imm;
        logic [8:0]  ctrl;  // {ill, regwr, memwr, alusrc, branch, ressrc[1:0], aluop[1:0]}
        logic [3:0]  hz;    // {StallF, StallD, FlushD, FlushE}
    } vec_t;

    vec_t tbl [18];

    function automatic logic [8:0] ctl(input logic ill, input logic rw, input logic mw,
                                       input logic as, input logic br,
                                       input logic [1:0] rs, input logic [1:0] aop);
        return {ill, rw, mw, as, br, rs, aop};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [1:0] rs_e, input logic [4:0] rd_e,
                         input logic pc);
        b0.Instr_D = instr; b0.ResultSrc_E = rs_e; b0.Rd_E = rd_e; b0.PCSrc_E = pc;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] val);
        b0.RegWrite_W = we; b0.Rd_W = rd; b0.Result_W = val;
    endtask

    function automatic logic [31:0] ctl_of0();
        return {23'd0, b0.IllegalInstr_D, b0.RegWrite_D, b0.MemWrite_D, b0.ALUSrc_D,
                b0.Branch_D, b0.ResultSrc_D, b0.ALUOp_D};
    endfunction

    function automatic logic [31:0] hz_of0();
        return {28'd0, b0.StallF, b0.StallD, b0.FlushD, b0.FlushE};
    endfunction

    task automatic chk_cnt(input string nm);
        int sat1;
        sat1 = (exp_cnt > 7) ? 7 : exp_cnt;
        chk({nm, " cnt0"}, {16'd0, b0.StallCnt}, exp_cnt);
        chk({nm, " cnt1"}, {29'd0, b1.StallCnt}, sat1);
    endtask

    initial begin
        logic [31:0] ins;
        // name, instr, ResultSrc_E, Rd_E, PCSrc_E, chk_imm, imm, ctrl, hazards
        tbl[0]  = '{"add",          32'h00528333, 2'b00, 5'd0,  1'b0, 1'b0, 32'h0,        ctl(0,1,0,0,0,2'b00,2'b10), 4'b0000};
        tbl[1]  = '{"sw -4",        32'hFFC42E23, 2'b00, 5'd0,  1'b0, 1'b1, 32'hFFFFFFFC, ctl(0,0,1,1,0,2'b00,2'b00), 4'b0000};
        tbl[2]  = '{"lw -4",        32'hFFC42303, 2'b00, 5'd0,  1'b0, 1'b1, 32'hFFFFFFFC, ctl(0,1,0,1,0,2'b01,2'b00), 4'b0000};
        tbl[3]  = '{"beq -8",       32'hFE208CE3, 2'b00, 5'd0,  1'b0, 1'b1, 32'hFFFFFFF8, ctl(0,0,0,0,1,2'b00,2'b01), 4'b0000};
        tbl[4]  = '{"addi -1",      32'hFFF00093, 2'b00, 5'd0,  1'b0, 1'b1, 32'hFFFFFFFF, ctl(0,1,0,1,0,2'b00,2'b10), 4'b0000};
        tbl[5]  = '{"addi imm=rdE", 32'h00508313, 2'b01, 5'd5,  1'b0, 1'b1, 32'h00000005, ctl(0,1,0,1,0,2'b00,2'b10), 4'b0000};
        tbl[6]  = '{"lu rs1",       32'h00028333, 2'b01, 5'd5,  1'b0, 1'b0, 32'h0,        ctl(0,1,0,0,0,2'b00,2'b10), 4'b1101};
        tbl[7]  = '{"lu rdE=0",     32'h00028333, 2'b01, 5'd0,  1'b0, 1'b0, 32'h0,        ctl(0,1,0,0,0,2'b00,2'b10), 4'b0000};
        tbl[8]  = '{"lu R rs2",     32'h00500333, 2'b01, 5'd5,  1'b0, 1'b0, 32'h0,        ctl(0,1,0,0,0,2'b00,2'b10), 4'b1101};
        tbl[9]  = '{"lu S rs2",     32'hFFC42E23, 2'b01, 5'd28, 1'b0, 1'b1, 32'hFFFFFFFC, ctl(0,0,1,1,0,2'b00,2'b00), 4'b1101};
        tbl[10] = '{"lu B rs2",     32'hFE208CE3, 2'b01, 5'd2,  1'b0, 1'b1, 32'hFFFFFFF8, ctl(0,0,0,0,1,2'b00,2'b01), 4'b1101};
        tbl[11] = '{"lu lw rs1",    32'hFFC42303, 2'b01, 5'd8,  1'b0, 1'b1, 32'hFFFFFFFC, ctl(0,1,0,1,0,2'b01,2'b00), 4'b1101};
        tbl[12] = '{"lw imm=rdE",   32'hFFC42303, 2'b01, 5'd28, 1'b0, 1'b1, 32'hFFFFFFFC, ctl(0,1,0,1,0,2'b01,2'b00), 4'b0000};
        tbl[13] = '{"EX pc4",       32'h00028333, 2'b10, 5'd5,  1'b0, 1'b0, 32'h0,        ctl(0,1,0,0,0,2'b00,2'b10), 4'b0000};
        tbl[14] = '{"taken br",     32'h00028333, 2'b00, 5'd5,  1'b1, 1'b0, 32'h0,        ctl(0,1,0,0,0,2'b00,2'b10), 4'b0011};
        tbl[15] = '{"op 7F",        32'h0000007F, 2'b00, 5'd0,  1'b0, 1'b1, 32'h0,        ctl(1,0,0,0,0,2'b00,2'b00), 4'b0000};
        tbl[16] = '{"op 00",        32'h00000000, 2'b00, 5'd0,  1'b0, 1'b1, 32'h0,        ctl(1,0,0,0,0,2'b00,2'b00), 4'b0000};
        tbl[17] = '{"lui illegal",  32'h000002B7, 2'b00, 5'd0,  1'b0, 1'b1, 32'h0,        ctl(1,0,0,0,0,2'b00,2'b00), 4'b0000};

        // Reset: hazards forced low even with load-use and taken branch presented
        wb(1'b0, 5'd0, 32'h0);
        drive(32'h00028333, 2'b01, 5'd5, 1'b1);
        @(negedge clk); #2;
        chk("rst hazards", hz_of0(), 32'h0);
        chk("rst hazards dut1", {28'd0, b1.StallF, b1.StallD, b1.FlushD, b1.FlushE}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h00528333, 2'b00, 5'd0, 1'b0);
        @(negedge clk); #2;
        chk_cnt("post-rst");
        chk("post-rst x5", b0.RD1_D, 32'h0);

        // Write x5 then read it back through add x6,x5,x5
        wb(1'b1, 5'd5, 32'hDEADBEEF);
        drive(32'h00000000, 2'b00, 5'd0, 1'b0);
        @(negedge clk);
        wb(1'b0, 5'd0, 32'h0);
        drive(32'h00528333, 2'b00, 5'd0, 1'b0);
        #2;
        chk("add rd1", b0.RD1_D, 32'hDEADBEEF);
        chk("add rd2", b0.RD2_D, 32'hDEADBEEF);
        chk("add ctrl", ctl_of0(), {23'd0, ctl(0,1,0,0,0,2'b00,2'b10)});
        chk("add fields", {13'd0, b0.Funct7_5_D, b0.Funct3_D, b0.Rs2_D, b0.Rs1_D, b0.Rd_D},
            {13'd0, 1'b0, 3'd0, 5'd5, 5'd5, 5'd6});
        chk("nobyp x5", b1.RD1_D, 32'hDEADBEEF);

        // Bypass: x7 old value, then same-cycle overwrite
        @(negedge clk);
        wb(1'b1, 5'd7, 32'h11111111);
        drive(32'h00000000, 2'b00, 5'd0, 1'b0);
        @(negedge clk);
        wb(1'b1, 5'd7, 32'h12345678);
        drive(32'h00738433, 2'b00, 5'd0, 1'b0);
        #2;
        chk("byp rd1", b0.RD1_D, 32'h12345678);
        chk("byp rd2", b0.RD2_D, 32'h12345678);
        chk("nobyp old", b1.RD1_D, 32'h11111111);
        @(negedge clk);
        wb(1'b0, 5'd0, 32'h0);
        #2;
        chk("nobyp stored", b1.RD1_D, 32'h12345678);
        // Write to x0 ignored, including bypass
        wb(1'b1, 5'd0, 32'hFFFFFFFF);
        drive(32'h000000B3, 2'b00, 5'd0, 1'b0);
        #2;
        chk("x0 byp", b0.RD1_D, 32'h0);
        @(negedge clk);
        wb(1'b0, 5'd0, 32'h0);
        #2;
        chk("x0 stored", b0.RD2_D, 32'h0);
        chk("x0 stored dut1", b1.RD1_D, 32'h0);

        // Field extraction on a store
        drive(32'hFFC42E23, 2'b00, 5'd0, 1'b0);
        #1;
        chk("sw fields", {13'd0, b0.Funct7_5_D, b0.Funct3_D, b0.Rs2_D, b0.Rs1_D, b0.Rd_D},
            {13'd0, 1'b1, 3'd2, 5'd28, 5'd8, 5'd28});

        // Vector table, one clock per vector so the stall counter can be tracked
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(tbl[i].instr, tbl[i].rs_e, tbl[i].rd_e, tbl[i].pc);
            #2;
            chk({tbl[i].name, " ctrl"}, ctl_of0(), {23'd0, tbl[i].ctrl});
            chk({tbl[i].name, " hz"}, hz_of0(), {28'd0, tbl[i].hz});
            if (tbl[i].chk_imm) chk({tbl[i].name, " imm"}, b0.ImmExt_D, tbl[i].imm);
            if (tbl[i].hz[2]) exp_cnt++;
        end
        @(negedge clk);
        drive(32'h00000000, 2'b00, 5'd0, 1'b0);
        #2;
        chk_cnt("after table");

        // Three consecutive load-use stalls
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(32'h00028333, 2'b01, 5'd5, 1'b0);
            #2;
            chk("lu seq hz", hz_of0(), 32'b1101);
            exp_cnt++;
        end
        @(negedge clk);
        drive(32'h00000000, 2'b00, 5'd0, 1'b0);
        #2;
        chk_cnt("3 stalls");

        // Load-use with taken branch: flush wins, counter holds
        @(negedge clk);
        drive(32'h00028333, 2'b01, 5'd5, 1'b1);
        #2;
        chk("lu+br hz", hz_of0(), 32'b0011);
        @(negedge clk);
        drive(32'h00000000, 2'b00, 5'd0, 1'b0);
        #2;
        chk_cnt("lu+br");

        // Push the narrow counter past its ceiling
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(32'h00500333, 2'b01, 5'd5, 1'b0);
            exp_cnt++;
        end
        @(negedge clk);
        drive(32'h00000000, 2'b00, 5'd0, 1'b0);
        #2;
        chk_cnt("saturate");

        // Fill x1..x31, then reset mid-run with a WB write pending
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            wb(1'b1, 5'(i), 32'hA5000000 | 32'(i));
        end
        @(negedge clk);
        wb(1'b0, 5'd0, 32'h0);
        ins = {7'd0, 5'd31, 5'd31, 3'd0, 5'd1, 7'b0110011};
        drive(ins, 2'b00, 5'd0, 1'b0);
        #2;
        chk("x31 before rst", b0.RD1_D, 32'hA500001F);
        @(negedge clk);
        rst = 1'b1;
        wb(1'b1, 5'd9, 32'hAAAA5555);
        @(negedge clk);
        rst = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        exp_cnt = 0;
        for (int i = 1; i < 32; i++) begin
            ins = {7'd0, 5'(i), 5'(i), 3'd0, 5'd1, 7'b0110011};
            drive(ins, 2'b00, 5'd0, 1'b0);
            #1;
            chk($sformatf("rst x%0d rd1", i), b0.RD1_D, 32'h0);
            chk($sformatf("rst x%0d rd2", i), b0.RD2_D, 32'h0);
            chk($sformatf("rst x%0d dut1", i), b1.RD1_D, 32'h0);
        end
        chk_cnt("mid rst");
        drive(32'h0000007F, 2'b00, 5'd0, 1'b0);
        #1;
        chk("rst op 7F ctrl", ctl_of0(), {23'd0, ctl(1,0,0,0,0,2'b00,2'b00)});
        chk("rst op 7F imm", b0.ImmExt_D, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
